tlb_write_ctrl: RTL and testbench
=================================

# tlb_write_ctrl

Write-side sequencer for the cascaded TLB header chain. It executes TLBWI and TLBWR by broadcasting the target index to all 32 header entries and locating the entry that holds that index. It then pulses the shift enables of chain positions 0..p so that the new {index, content} word enters at the chain head and overwrites position p (move-to-front). It also owns the CP0 Random and Wired registers that select the TLBWR victim.

## Interface
- N_ENTRY, 32, chain length; equals the 5-bit index space.
- RANDOM_TOP, 5'd31, Random value after reset, after any Wired write and on wrap.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req  in  1  single-cycle write request pulse; sampled only in IDLE
- useRandom  in  1  0 = TLBWI (target is indexReg), 1 = TLBWR (target is current Random)
- indexReg  in  5  CP0 Index[4:0]
- pageMask  in  16  entry PageMask
- vpn2  in  19  entry VPN2
- g  in  1  entry global bit (AND of EntryLo0.G and EntryLo1.G, formed upstream)
- asid  in  8  entry ASID
- wiredWe  in  1  write strobe for Wired
- wiredIn  in  5  new Wired value
- indexMatch  in  32  bit p = indexMatch output of chain position p (position 0 = head)
- indexSel  out  5  index broadcast to every header's indexIn
- shift  out  32  bit p = shift enable of chain position p
- cascadeHead  out  49  {index[4:0], pageMask, vpn2, g, asid} into position 0 cascadeDin
- wired  out  5  CP0 Wired
- random  out  5  CP0 Random
- busy  out  1  high in every state except IDLE
- ack  out  1  one-cycle completion pulse
- err  out  1  qualifies ack: no chain position matched indexSel, and no write was done

## Operation
- States: IDLE, LOOKUP, SHIFT, DONE.
- IDLE, req=1:
  - latch target = useRandom ? random : indexReg into indexSel.
  - latch the entry fields into the cascadeHead content.
  - go to LOOKUP.
- LOOKUP:
  - p = lowest set bit of indexMatch.
  - Register shiftMask = bits 0..p set.
  - If indexMatch == 0, register no-match and leave shiftMask = 0.
  - Go to SHIFT.
- SHIFT: drive shift = shiftMask for exactly this cycle; go to DONE.
- DONE: ack=1, err=no-match; go to IDLE.
- req while busy is dropped; there is no queueing.
- Random:
  - decrements by 1 every cycle.
  - when random == wired or random == 0, the next value is RANDOM_TOP.
  - if wired == 31, Random holds at 31.
- wiredWe: wired <= wiredIn and random <= RANDOM_TOP in the same edge; the Wired write takes priority over the decrement.
- A TLBWR accepted in the same cycle as wiredWe uses the pre-update Random value.
- Multiple indexMatch bits mean a corrupt chain. The lowest position wins and err stays 0.
- Reset values:
  - state IDLE; indexSel 0; cascadeHead 0.
  - shift 0; ack 0; err 0; busy 0.
  - wired 0; random RANDOM_TOP.

## Timing
- All outputs are registered or decoded from registered state. shift must never glitch.
- Cycle 0: req sampled at the edge.
- Cycle 1 (LOOKUP): indexSel is valid and indexMatch returns combinationally from the headers.
- Cycle 2 (SHIFT): shift is asserted. cascadeHead is stable from cycle 1 until the next accepted req.
- Cycle 3 (DONE): ack is asserted. Fixed latency from req to ack is 3 cycles.
- Earliest next accept is the cycle after DONE, giving a 4-cycle throughput.
- Reset asserted in any state:
  - immediately forces IDLE and shift=0, so no partial shift occurs.
  - an in-flight request is lost with no ack.
- Headers update on the SHIFT edge. indexMatch for the same index is then at position 0.

## Test plan
- Reset, then TLBWI with indexReg=7 on the default chain (position p holds index p) -> shift=32'h0000_00FF in cycle 2; ack in cycle 3 with err=0; afterwards position 0 holds index 7.
- Repeat TLBWI with index 7 -> indexMatch=bit0, shift=32'h1, the head entry is rewritten in place, ack with err=0.
- Force indexMatch=0 during LOOKUP -> shift stays 0, ack=1 with err=1.
- Write Wired=28, then run freely -> Random sequence 31,30,29,28,31,… Write Wired=31 -> Random holds at 31.
- TLBWR issued with wiredWe in the same cycle while random=20 -> indexSel=20; Random reads 31 the next cycle.
- Assert rst during SHIFT -> shift drops asynchronously, no ack, busy=0, wired=0, random=31.
- req pulses during LOOKUP and during DONE -> ignored; exactly one ack per accepted req.

Source files
------------

// File: rtl/tlb_write_ctrl.sv
// Write-side sequencer for the cascaded TLB header chain (TLBWI/TLBWR move-to-front)
// plus the CP0 Random/Wired victim-selection registers.
module tlb_write_ctrl #(
    parameter int unsigned N_ENTRY    = 32,
    parameter logic [4:0]  RANDOM_TOP = 5'd31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                useRandom,
    input  logic [4:0]          indexReg,
    input  logic [15:0]         pageMask,
    input  logic [18:0]         vpn2,
    input  logic                g,
    input  logic [7:0]          asid,
    input  logic                wiredWe,
    input  logic [4:0]          wiredIn,
    input  logic [N_ENTRY-1:0]  indexMatch,
    output logic [4:0]          indexSel,
    output logic [N_ENTRY-1:0]  shift,
    output logic [48:0]         cascadeHead,
    output logic [4:0]          wired,
    output logic [4:0]          random,
    output logic                busy,
    output logic                ack,
    output logic                err
);

    localparam int unsigned CONTENT_W = 44;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [CONTENT_W-1:0]   content;
    logic [CONTENT_W-1:0]   content_n;
    logic [4:0]             index_sel_n;
    logic [N_ENTRY-1:0]     shift_n;
    logic [N_ENTRY-1:0]     match_mask;
    logic                   no_match;
    logic                   no_match_n;
    logic                   busy_n;
    logic                   ack_n;
    logic                   err_n;
    logic [4:0]             wired_n;
    logic [4:0]             random_n;

    assign cascadeHead = {indexSel, content};

    // Bits 0..p set, p = lowest matching chain position; x ^ (x-1) yields exactly that.
    always_comb begin
        match_mask = '0;
        if (indexMatch != '0) begin
            match_mask = indexMatch ^ (indexMatch - N_ENTRY'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-value decode for the write sequence.
    always_comb begin
        state_n     = state;
        index_sel_n = indexSel;
        content_n   = content;
        no_match_n  = no_match;
        shift_n     = '0;
        ack_n       = 1'b0;
        err_n       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    index_sel_n = useRandom ? random : indexReg;
                    content_n   = {pageMask, vpn2, g, asid};
                    state_n     = LOOKUP;
                end
            end
            LOOKUP: begin
                shift_n    = match_mask;
                no_match_n = (indexMatch == '0);
                state_n    = SHIFT;
            end
            SHIFT: begin
                ack_n   = 1'b1;
                err_n   = no_match;
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // Shift enables come straight from a flop so they cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            indexSel <= '0;
            content  <= '0;
            no_match <= 1'b0;
            shift    <= '0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else begin
            indexSel <= index_sel_n;
            content  <= content_n;
            no_match <= no_match_n;
            shift    <= shift_n;
            busy     <= busy_n;
            ack      <= ack_n;
            err      <= err_n;
        end
    end

    // Random counts down toward Wired and wraps to the top; a Wired write restarts it.
    always_comb begin
        wired_n  = wired;
        random_n = random;
        if (wiredWe) begin
            wired_n  = wiredIn;
            random_n = RANDOM_TOP;
        end else if (wired == RANDOM_TOP || random == wired || random == 5'd0) begin
            random_n = RANDOM_TOP;
        end else begin
            random_n = random - 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wired  <= 5'd0;
            random <= RANDOM_TOP;
        end else begin
            wired  <= wired_n;
            random <= random_n;
        end
    end

endmodule

// File: tb/tb_tlb_write_ctrl.sv
// Randomized bench for tlb_write_ctrl: emulates the header chain and checks against
// an MRU-order list model plus a rule-level Random/Wired model.
module tb_tlb_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        useRandom;
    logic [4:0]  indexReg;
    logic [15:0] pageMask;
    logic [18:0] vpn2;
    logic        g;
    logic [7:0]  asid;
    logic        wiredWe;
    logic [4:0]  wiredIn;
    logic [31:0] indexMatch;
    logic [4:0]  indexSel;
    logic [31:0] shift;
    logic [48:0] cascadeHead;
    logic [4:0]  wired;
    logic [4:0]  random;
    logic        busy;
    logic        ack;
    logic        err;

    tlb_write_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .useRandom(useRandom), .indexReg(indexReg),
        .pageMask(pageMask), .vpn2(vpn2), .g(g), .asid(asid),
        .wiredWe(wiredWe), .wiredIn(wiredIn), .indexMatch(indexMatch),
        .indexSel(indexSel), .shift(shift), .cascadeHead(cascadeHead),
        .wired(wired), .random(random), .busy(busy), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_ack = 0;
    int exp_acks = 0;
    bit mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Header chain emulation: positions shift toward the tail when enabled.
    logic [4:0]  chain [32];
    logic [31:0] match_chain;
    logic        hdr_init;
    logic        force_on;
    logic [31:0] force_val;

    always @(posedge clk) begin
        for (int k = 0; k < 32; k++) begin
            if (hdr_init) chain[k] <= 5'(k);
            else if (shift[k]) chain[k] <= (k == 0) ? cascadeHead[48:44] : chain[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < 32; k++) match_chain[k] = (chain[k] == indexSel);
    end

    assign indexMatch = force_on ? force_val : match_chain;

    // Random/Wired reference from the architectural rules.
    logic [4:0] rm;
    logic [4:0] wm;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wm <= 5'd0;
            rm <= 5'd31;
        end else if (wiredWe) begin
            wm <= wiredIn;
            rm <= 5'd31;
        end else if (wm == 5'd31 || rm == wm || rm == 5'd0) begin
            rm <= 5'd31;
        end else begin
            rm <= rm - 5'd1;
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("random", 64'(random), 64'(rm));
            check("wired", 64'(wired), 64'(wm));
        end
        if (ack) n_ack++;
    end

    // MRU-order model: order[i] is the index held at chain position i.
    int order [32];

    function automatic int pos_of(input logic [4:0] t);
        for (int i = 0; i < 32; i++) if (order[i] == int'(t)) return i;
        return -1;
    endfunction

    task automatic move_front(input int p);
        int t;
        t = order[p];
        for (int i = p; i > 0; i--) order[i] = order[i-1];
        order[0] = t;
    endtask

    // One write transaction; entered and left just after a falling edge.
    task automatic do_txn(input bit use_rnd, input logic [4:0] idx, input int fmode,
                          input bit wwe, input logic [4:0] win, input bit spur);
        logic [4:0]  tgt;
        logic [43:0] fields;
        logic [31:0] exp_mask;
        bit          exp_err;
        int          p;
        int          q;
        fields = {12'($urandom), $urandom};
        tgt = use_rnd ? rm : idx;
        req = 1'b1; useRandom = use_rnd; indexReg = idx;
        {pageMask, vpn2, g, asid} = fields;
        wiredWe = wwe; wiredIn = win;
        @(negedge clk);
        req = 1'b0; wiredWe = 1'b0;
        {pageMask, vpn2, g, asid} = {12'($urandom), $urandom};
        indexReg = 5'($urandom);
        check("lookup_indexSel", 64'(indexSel), 64'(tgt));
        check("lookup_head", 64'(cascadeHead), 64'({tgt, fields}));
        check("lookup_busy", 64'(busy), 64'd1);
        check("lookup_shift", 64'(shift), 64'd0);
        p = pos_of(tgt);
        exp_err = 1'b0;
        if (fmode == 1) begin
            force_on = 1'b1; force_val = '0; exp_err = 1'b1;
        end else if (fmode == 2 && p < 31) begin
            q = int'($urandom_range(31, p + 1));
            force_on = 1'b1; force_val = (32'd1 << p) | (32'd1 << q);
        end
        exp_mask = '0;
        if (!exp_err) for (int i = 0; i <= p; i++) exp_mask[i] = 1'b1;
        if (spur) req = 1'b1;
        @(negedge clk);
        req = 1'b0; force_on = 1'b0;
        check("shift_mask", 64'(shift), 64'(exp_mask));
        check("shift_ack", 64'(ack), 64'd0);
        @(negedge clk);
        check("done_ack", 64'(ack), 64'd1);
        check("done_err", 64'(err), 64'(exp_err));
        check("done_shift", 64'(shift), 64'd0);
        check("done_busy", 64'(busy), 64'd1);
        if (spur) req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("idle_ack", 64'(ack), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        if (!exp_err) begin
            check("chain_head", 64'(chain[0]), 64'(tgt));
            move_front(p);
        end
        exp_acks++;
    endtask

    task automatic write_wired(input logic [4:0] w);
        wiredWe = 1'b1; wiredIn = w;
        @(negedge clk);
        wiredWe = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; hdr_init = 1'b1; req = 1'b0; useRandom = 1'b0; indexReg = '0;
        pageMask = '0; vpn2 = '0; g = 1'b0; asid = '0; wiredWe = 1'b0; wiredIn = '0;
        force_on = 1'b0; force_val = '0;
        for (int i = 0; i < 32; i++) order[i] = i;
        repeat (3) @(negedge clk);
        check("rst_indexSel", 64'(indexSel), 64'd0);
        check("rst_head", 64'(cascadeHead), 64'd0);
        check("rst_shift", 64'(shift), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wired", 64'(wired), 64'd0);
        check("rst_random", 64'(random), 64'd31);
        rst = 1'b0; hdr_init = 1'b0; mon_en = 1'b1;
        @(negedge clk);

        // Directed: TLBWI 7 twice, then forced no-match, then corrupt-chain multi-match.
        do_txn(1'b0, 5'd7, 0, 1'b0, 5'd0, 1'b0);
        do_txn(1'b0, 5'd7, 0, 1'b0, 5'd0, 1'b1);
        do_txn(1'b0, 5'd12, 1, 1'b0, 5'd0, 1'b0);
        do_txn(1'b0, 5'd3, 2, 1'b0, 5'd0, 1'b1);

        // Wired sweep: 28 wraps 31..28, 31 holds.
        write_wired(5'd28);
        repeat (10) @(negedge clk);
        write_wired(5'd31);
        repeat (6) @(negedge clk);

        // TLBWR with simultaneous Wired write while Random == 20.
        write_wired(5'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (rm == 5'd20) found = 1'b1;
            else @(negedge clk);
        end
        check("wait_random20", 64'(found), 64'd1);
        check("random_is_20", 64'(random), 64'd20);
        do_txn(1'b1, 5'd0, 0, 1'b1, 5'd4, 1'b0);

        // Reset during SHIFT drops the shift enables and the in-flight request.
        write_wired(5'd5);
        req = 1'b1; useRandom = 1'b0; indexReg = 5'd9;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("pre_rst_shift", 64'(shift != '0), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_shift", 64'(shift), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_ack", 64'(ack), 64'd0);
        check("rst_mid_wired", 64'(wired), 64'd0);
        check("rst_mid_random", 64'(random), 64'd31);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_ack", 64'(ack), 64'd0);
            check("post_rst_busy", 64'(busy), 64'd0);
        end

        // Randomized mix of TLBWI/TLBWR, forced faults, Wired writes and stray reqs.
        for (int n = 0; n < 40; n++) begin
            int r;
            int fm;
            r  = int'($urandom_range(99, 0));
            fm = (r < 70) ? 0 : (r < 85) ? 1 : 2;
            do_txn(1'($urandom), 5'($urandom), fm, ($urandom_range(4, 0) == 0),
                   5'($urandom), 1'($urandom));
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("ack_count", 64'(n_ack), 64'(exp_acks));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
